// File: rtl/pmod_stand_spi_solo_pkg.sv
// rtl/pmod_stand_spi_solo_pkg.sv - shared types and constants for the ACL2 PMOD path
package pmod_stand_spi_solo_pkg;

   // raw 8-byte ADXL362 snapshot: XL XH YL YH ZL ZH TL TH, MSB first
   typedef logic [63:0] t_pmod_acl2_reg_8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CONVERT,
      ST_EMIT,
      ST_EOL
   } t_fmt_state;

   localparam logic [7:0] ASCII_X     = 8'h58;
   localparam logic [7:0] ASCII_Y     = 8'h59;
   localparam logic [7:0] ASCII_Z     = 8'h5A;
   localparam logic [7:0] ASCII_T     = 8'h54;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   localparam int OFS_XL = 56;
   localparam int OFS_XH = 48;
   localparam int OFS_YL = 40;
   localparam int OFS_YH = 32;
   localparam int OFS_ZL = 24;
   localparam int OFS_ZH = 16;
   localparam int OFS_TL = 8;
   localparam int OFS_TH = 0;

   // 12-bit two's complement field {H[3:0], L}; the upper nibble of H is not part of the reading
   function automatic logic [11:0] field_value(input t_pmod_acl2_reg_8 snap, input logic [1:0] idx);
      case (idx)
         2'd0:    field_value = {snap[OFS_XH +: 4], snap[OFS_XL +: 8]};
         2'd1:    field_value = {snap[OFS_YH +: 4], snap[OFS_YL +: 8]};
         2'd2:    field_value = {snap[OFS_ZH +: 4], snap[OFS_ZL +: 8]};
         default: field_value = {snap[OFS_TH +: 4], snap[OFS_TL +: 8]};
      endcase
   endfunction

   function automatic logic [7:0] field_letter(input logic [1:0] idx);
      case (idx)
         2'd0:    field_letter = ASCII_X;
         2'd1:    field_letter = ASCII_Y;
         2'd2:    field_letter = ASCII_Z;
         default: field_letter = ASCII_T;
      endcase
   endfunction

endpackage

// File: rtl/bin12_to_bcd4.sv
// rtl/bin12_to_bcd4.sv - iterative 12-bit binary to 4-digit BCD converter (double dabble)
module bin12_to_bcd4 (
   input  logic        i_clk_20mhz,
   input  logic        i_rstn_20mhz,
   input  logic        i_start,
   input  logic [11:0] i_bin,
   output logic        o_done,
   output logic [15:0] o_bcd
);

   // [27:12] BCD digits, [11:0] remaining binary bits
   logic [27:0] sr;
   logic [27:0] sr_adj;
   logic [3:0]  iter_left;

   // add 3 to every digit that would overflow past 9 when doubled
   always_comb begin
      sr_adj = sr;
      for (int d = 0; d < 4; d++) begin
         if (sr[12 + 4*d +: 4] >= 4'd5) begin
            sr_adj[12 + 4*d +: 4] = sr[12 + 4*d +: 4] + 4'd3;
         end
      end
   end

   // first shift is folded into the start cycle (digits are zero, so no correction is needed)
   always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
      if (!i_rstn_20mhz) begin
         sr        <= '0;
         iter_left <= '0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_start) begin
            sr        <= {15'd0, i_bin, 1'b0};
            iter_left <= 4'd11;
         end else if (iter_left != 4'd0) begin
            sr        <= {sr_adj[26:0], 1'b0};
            iter_left <= iter_left - 4'd1;
            o_done    <= (iter_left == 4'd1);
         end
      end
   end

   assign o_bcd = sr[27:12];

endmodule

// File: rtl/acl2_reading_formatter.sv
// rtl/acl2_reading_formatter.sv - ACL2 snapshot to ASCII text line formatter; ACL2_FMT_TEMP_EN adds the T field
module acl2_reading_formatter
   import pmod_stand_spi_solo_pkg::*;
#(
   parameter int parm_line_cnt_bits = 16
) (
   input  logic                          i_clk_20mhz,
   input  logic                          i_rstn_20mhz,
   input  t_pmod_acl2_reg_8              i_data_3axis_temp,
   input  logic                          i_data_valid,
   output logic [7:0]                    o_tx_byte,
   output logic                          o_tx_valid,
   input  logic                          i_tx_ready,
   output logic                          o_busy,
   output logic                          o_overrun,
   input  logic                          i_clr_overrun,
   output logic [parm_line_cnt_bits-1:0] o_line_count
);

`ifdef ACL2_FMT_TEMP_EN
   localparam logic [1:0] LAST_FIELD = 2'd3;
`else
   localparam logic [1:0] LAST_FIELD = 2'd2;
`endif
   localparam logic [parm_line_cnt_bits-1:0] LINE_ONE = 1;

   t_fmt_state       state;
   t_fmt_state       state_next;
   t_pmod_acl2_reg_8 snap;
   logic [1:0]       fidx;
   logic [2:0]       bidx;
   logic             sign_q;
   logic [11:0]      fval;
   logic [11:0]      mag;
   logic             conv_start;
   logic             conv_done;
   logic [15:0]      bcd;
   logic             last_field;
   logic             field_last_byte;
   logic             accept;
   logic             unused_snap_bits;

   assign fval            = field_value(snap, fidx);
   assign mag             = fval[11] ? (12'd0 - fval) : fval;
   assign last_field      = (fidx == LAST_FIELD);
   assign field_last_byte = last_field ? (bidx == 3'd5) : (bidx == 3'd6);
   assign accept          = o_tx_valid && i_tx_ready;
   assign o_busy          = (state != ST_IDLE);
   assign unused_snap_bits = ^snap;

   bin12_to_bcd4 u_bcd (
      .i_clk_20mhz  (i_clk_20mhz),
      .i_rstn_20mhz (i_rstn_20mhz),
      .i_start      (conv_start),
      .i_bin        (mag),
      .o_done       (conv_done),
      .o_bcd        (bcd)
   );

   // state register
   always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
      if (!i_rstn_20mhz) state <= ST_IDLE;
      else               state <= state_next;
   end

   // next state and the byte stream; bytes derive from registers only, so they hold until accepted
   always_comb begin
      state_next = state;
      o_tx_valid = 1'b0;
      o_tx_byte  = 8'h00;
      conv_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_data_valid) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            conv_start = 1'b1;
            state_next = ST_CONVERT;
         end
         ST_CONVERT: begin
            if (conv_done) state_next = ST_EMIT;
         end
         ST_EMIT: begin
            o_tx_valid = 1'b1;
            case (bidx)
               3'd0:    o_tx_byte = field_letter(fidx);
               3'd1:    o_tx_byte = sign_q ? ASCII_MINUS : ASCII_PLUS;
               3'd2:    o_tx_byte = ASCII_ZERO | {4'h0, bcd[15:12]};
               3'd3:    o_tx_byte = ASCII_ZERO | {4'h0, bcd[11:8]};
               3'd4:    o_tx_byte = ASCII_ZERO | {4'h0, bcd[7:4]};
               3'd5:    o_tx_byte = ASCII_ZERO | {4'h0, bcd[3:0]};
               default: o_tx_byte = ASCII_SPACE;
            endcase
            if (i_tx_ready && field_last_byte) state_next = last_field ? ST_EOL : ST_LOAD;
         end
         ST_EOL: begin
            o_tx_valid = 1'b1;
            o_tx_byte  = bidx[0] ? ASCII_LF : ASCII_CR;
            if (i_tx_ready && bidx[0]) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // snapshot capture, field/byte indices and sign latch
   always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
      if (!i_rstn_20mhz) begin
         snap   <= '0;
         fidx   <= '0;
         bidx   <= '0;
         sign_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_data_valid) begin
                  snap <= i_data_3axis_temp;
                  fidx <= 2'd0;
               end
            end
            ST_LOAD: begin
               sign_q <= fval[11];
               bidx   <= 3'd0;
            end
            ST_EMIT: begin
               if (accept) begin
                  if (field_last_byte) begin
                     bidx <= 3'd0;
                     if (!last_field) fidx <= fidx + 2'd1;
                  end else begin
                     bidx <= bidx + 3'd1;
                  end
               end
            end
            ST_EOL: begin
               if (accept) bidx <= bidx[0] ? 3'd0 : 3'd1;
            end
            default: ;
         endcase
      end
   end

   // sticky overrun (a dropped snapshot beats a simultaneous clear) and completed-line counter
   always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
      if (!i_rstn_20mhz) begin
         o_overrun    <= 1'b0;
         o_line_count <= '0;
      end else begin
         if (i_data_valid && state != ST_IDLE) o_overrun <= 1'b1;
         else if (i_clr_overrun)               o_overrun <= 1'b0;
         if (state == ST_EOL && accept && bidx[0]) o_line_count <= o_line_count + LINE_ONE;
      end
   end

endmodule

// File: tb/tb_acl2_reading_formatter.sv
// tb/tb_acl2_reading_formatter.sv - randomized self-checking bench for acl2_reading_formatter
module tb_acl2_reading_formatter;

`ifdef ACL2_FMT_TEMP_EN
   localparam int NUM_FIELDS  = 4;
   localparam int LINE_CYCLES = 82;
`else
   localparam int NUM_FIELDS  = 3;
   localparam int LINE_CYCLES = 62;
`endif
   localparam logic [63:0] SNAP_A = 64'hE803_FFFF_00F8_D200;

   logic        clk;
   logic        rst_n;
   logic [63:0] i_data_3axis_temp;
   logic        i_data_valid;
   logic [7:0]  o_tx_byte;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_overrun;
   logic        i_clr_overrun;
   logic [15:0] o_line_count;

   int          checks;
   int          errors;
   int          hold_bad;
   bit          rand_ready;
   logic [15:0] exp_lines;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];

   acl2_reading_formatter #(.parm_line_cnt_bits(16)) dut (
      .i_clk_20mhz       (clk),
      .i_rstn_20mhz      (rst_n),
      .i_data_3axis_temp (i_data_3axis_temp),
      .i_data_valid      (i_data_valid),
      .o_tx_byte         (o_tx_byte),
      .o_tx_valid        (o_tx_valid),
      .i_tx_ready        (i_tx_ready),
      .o_busy            (o_busy),
      .o_overrun         (o_overrun),
      .i_clr_overrun     (i_clr_overrun),
      .o_line_count      (o_line_count)
   );

   initial begin
      clk = 1'b0;
      forever #25 clk = ~clk;
   end

   initial begin
      i_tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // collect accepted bytes and watch that a stalled byte is held unchanged
   initial begin
      bit         stall;
      logic [7:0] stall_byte;
      stall = 1'b0;
      stall_byte = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall && (!o_tx_valid || o_tx_byte != stall_byte)) hold_bad++;
            if (o_tx_valid && i_tx_ready) rx_q.push_back(o_tx_byte);
            stall      = o_tx_valid && !i_tx_ready;
            stall_byte = o_tx_byte;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected text line straight from the field arithmetic
   task automatic build_exp(input logic [63:0] s);
      logic [7:0] letters [4];
      logic [7:0] lo;
      logic [7:0] hi;
      int         v;
      int         a;
      letters = '{8'h58, 8'h59, 8'h5A, 8'h54};
      exp_q.delete();
      for (int f = 0; f < NUM_FIELDS; f++) begin
         lo = s[63 - 16*f -: 8];
         hi = s[55 - 16*f -: 8];
         v  = {hi[3:0], lo};
         if (v >= 2048) v = v - 4096;
         a  = (v < 0) ? -v : v;
         exp_q.push_back(letters[f]);
         exp_q.push_back((v < 0) ? 8'h2D : 8'h2B);
         exp_q.push_back(8'(48 + a / 1000));
         exp_q.push_back(8'(48 + (a / 100) % 10));
         exp_q.push_back(8'(48 + (a / 10) % 10));
         exp_q.push_back(8'(48 + a % 10));
         if (f < NUM_FIELDS - 1) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // called at a negedge; pulse_at > 0 injects an extra snapshot (and optionally a clear) in that cycle
   task automatic run_line(input logic [63:0] s, input int pulse_at, input bit clr_at_pulse, input string tag);
      int cyc;
      int first_v;
      int done_c;
      build_exp(s);
      rx_q.delete();
      hold_bad = 0;
      i_data_3axis_temp = s;
      i_data_valid = 1'b1;
      cyc = 0;
      first_v = 0;
      done_c = 0;
      while (cyc < 1000 && done_c == 0) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({tag, "_busy_rise"}, o_busy, 1);
         if (o_tx_valid && first_v == 0) first_v = cyc;
         i_data_valid  = (cyc == pulse_at);
         i_clr_overrun = (cyc == pulse_at) && clr_at_pulse;
         if (cyc == pulse_at) i_data_3axis_temp = ~s;
         if (!o_busy) done_c = cyc;
      end
      i_data_valid  = 1'b0;
      i_clr_overrun = 1'b0;
      check({tag, "_first_valid"}, first_v, 14);
      check({tag, "_finished"}, done_c != 0, 1);
      if (!rand_ready) check({tag, "_cycles"}, done_c, LINE_CYCLES);
      check({tag, "_hold"}, hold_bad, 0);
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      end
      exp_lines = exp_lines + 16'd1;
      check({tag, "_line_count"}, o_line_count, exp_lines);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      hold_bad = 0;
      rand_ready = 1'b0;
      exp_lines = 16'd0;
      rst_n = 1'b0;
      i_data_valid = 1'b0;
      i_data_3axis_temp = '0;
      i_clr_overrun = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_valid", o_tx_valid, 0);
      check("rst_tx_byte", o_tx_byte, 0);
      check("rst_busy", o_busy, 0);
      check("rst_overrun", o_overrun, 0);
      check("rst_line_count", o_line_count, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_line(SNAP_A, 0, 1'b0, "basic");
      check("basic_overrun", o_overrun, 0);
      run_line(64'hFF07_01A0_0000_0000, 0, 1'b0, "b2b_edge");
      check("b2b_overrun", o_overrun, 0);
      run_line(64'h0, 0, 1'b0, "zero");

      rand_ready = 1'b1;
      run_line(SNAP_A, 0, 1'b0, "rand_ready");
      rand_ready = 1'b0;

      run_line(SNAP_A, 30, 1'b0, "overrun");
      check("overrun_set", o_overrun, 1);
      @(negedge clk) i_clr_overrun = 1'b1;
      @(negedge clk) i_clr_overrun = 1'b0;
      check("overrun_clr", o_overrun, 0);
      run_line(SNAP_A, 30, 1'b1, "set_wins");
      check("overrun_set_wins", o_overrun, 1);
      @(negedge clk) i_clr_overrun = 1'b1;
      @(negedge clk) i_clr_overrun = 1'b0;
      check("overrun_clr2", o_overrun, 0);

      rand_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         run_line({$urandom, $urandom}, 0, 1'b0, $sformatf("rnd%0d", n));
      end
      rand_ready = 1'b0;

      // abandon a line with reset; overrun is set first so its reset value is observable
      @(negedge clk);
      i_data_3axis_temp = SNAP_A;
      i_data_valid = 1'b1;
      @(negedge clk) i_data_valid = 1'b0;
      repeat (19) @(negedge clk);
      i_data_valid = 1'b1;
      @(negedge clk) i_data_valid = 1'b0;
      check("mid_overrun_set", o_overrun, 1);
      repeat (18) @(negedge clk);
      @(posedge clk);
      #5 rst_n = 1'b0;
      #1;
      check("mid_rst_tx_valid", o_tx_valid, 0);
      check("mid_rst_tx_byte", o_tx_byte, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_overrun", o_overrun, 0);
      check("mid_rst_line_count", o_line_count, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_lines = 16'd0;
      @(negedge clk);
      run_line(SNAP_A, 0, 1'b0, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
